// File: rtl/rf_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_arbiter_if
//  Description : Functional-unit result bus into the writeback arbiter.
//                One valid/ready pair per requester plus packed tag, rd and
//                data slices (slice i belongs to requester i).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [NREQ*5-1:0]     req_rd;
    logic [NREQ*XLEN-1:0]  req_data;

    // Functional-unit side: presents results, sees the grant.
    modport master (
        output req_valid, req_tag, req_rd, req_data,
        input  req_ready
    );

    // Arbiter side: consumes results, drives the grant.
    modport slave (
        input  req_valid, req_tag, req_rd, req_data,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_arbiter
//  Description : Shares the register-file write port among NREQ result
//                sources, broadcasts the granted result on the CDB and keeps
//                the busy/Qi producer-tag table used for renaming. The file
//                is written only when the result tag is still the newest
//                producer of rd.
//  Options     : RR_ARB_EN defined   -> round-robin arbitration
//                RR_ARB_EN undefined -> fixed priority, lowest index wins
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter #(
    parameter int NREQ  = 3,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rf_writeback_arbiter_if.slave fu,
    input  wire logic             iss_valid,
    input  wire logic [4:0]       iss_rd,
    input  wire logic [TAG_W-1:0] iss_tag,
    input  wire logic [4:0]       q_addr1,
    input  wire logic [4:0]       q_addr2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic [TAG_W-1:0]      q_tag1,
    output logic [TAG_W-1:0]      q_tag2,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [XLEN-1:0]       cdb_data,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [31:0]      r_busy;
    logic [TAG_W-1:0] r_qi [32];

    logic             r_cdb_valid;
    logic [TAG_W-1:0] r_cdb_tag;
    logic [XLEN-1:0]  r_cdb_data;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [XLEN-1:0]  r_rf_wdata;

    logic             w_found;
    logic [IDX_W-1:0] w_grant_idx;
    logic [NREQ-1:0]  w_grant;
    logic             w_grant_any;
    logic [TAG_W-1:0] w_sel_tag;
    logic [4:0]       w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;
    logic             w_rf_match;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        logic [IDX_W:0] j;
        w_found     = 1'b0;
        w_grant_idx = '0;
        j           = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (j >= (IDX_W+1)'(NREQ)) begin
                j = j - (IDX_W+1)'(NREQ);
            end
            if (!w_found && fu.req_valid[j[IDX_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = j[IDX_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= (w_grant_idx == IDX_W'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`else
    // Fixed priority: lowest asserted index wins (scan high to low, last hit stays).
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (fu.req_valid[k]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(k);
            end
        end
    end
`endif

    // One-hot grant, suppressed during reset so nothing is consumed.
    always_comb begin
        w_grant = '0;
        if (w_found && !reset) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_grant_any  = |w_grant;
    assign fu.req_ready = w_grant;

    // Steer the granted requester's tag/rd/data onto the result path.
    always_comb begin
        w_sel_tag  = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_tag  = fu.req_tag[i*TAG_W +: TAG_W];
                w_sel_rd   = fu.req_rd[i*5 +: 5];
                w_sel_data = fu.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Only the newest producer of rd may update the architectural register.
    assign w_rf_match = w_grant_any && (w_sel_rd != 5'd0) && r_busy[w_sel_rd] &&
                        (r_qi[w_sel_rd] == w_sel_tag);

    // Register the CDB broadcast and the filtered register-file write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
        end else begin
            r_cdb_valid <= w_grant_any;
            r_rf_we     <= w_rf_match;
            if (w_grant_any) begin
                r_cdb_tag  <= w_sel_tag;
                r_cdb_data <= w_sel_data;
            end
            if (w_rf_match) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    // Producer table: writeback clears busy, a later issue to the same rd overrides.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            for (int i = 0; i < 32; i++) begin
                r_qi[i] <= '0;
            end
        end else begin
            if (w_rf_match) begin
                r_busy[w_sel_rd] <= 1'b0;
            end
            if (iss_valid && (iss_rd != 5'd0)) begin
                r_busy[iss_rd] <= 1'b1;
                r_qi[iss_rd]   <= iss_tag;
            end
        end
    end

    assign q_busy1 = (q_addr1 != 5'd0) && r_busy[q_addr1];
    assign q_busy2 = (q_addr2 != 5'd0) && r_busy[q_addr2];
    assign q_tag1  = (q_addr1 != 5'd0) ? r_qi[q_addr1] : '0;
    assign q_tag2  = (q_addr2 != 5'd0) ? r_qi[q_addr2] : '0;

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
endmodule
`default_nettype wire

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single register-file write port between NREQ functional-unit result sources: ALU, MUL and load units.
- Maintains the per-register producer-tag table (busy + Qi) used by issue for renaming.
- Grants one result per cycle, broadcasts it on the CDB, and writes the register file only when the result's tag is still the newest producer of rd.
- Sits between the functional units and the register file; its registered write outputs feed the file's negedge write port.

Parameters:
- NREQ, 3, number of result requesters.
- TAG_W, 4, width of a reservation-station tag.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a result.
- req_ready  out  NREQ  one-hot grant; result i is consumed this cycle.
- req_tag  in  NREQ*TAG_W  producer tag per requester (slice i).
- req_rd  in  NREQ*5  destination register per requester.
- req_data  in  NREQ*XLEN  result data per requester.
- iss_valid  in  1  issue allocates a producer for iss_rd.
- iss_rd  in  5  destination of the issuing instruction.
- iss_tag  in  TAG_W  tag of the issuing instruction.
- q_addr1, q_addr2  in  5 each  status query addresses (rs1, rs2).
- q_busy1, q_busy2  out  1 each  register awaiting a producer.
- q_tag1, q_tag2  out  TAG_W each  pending producer tag.
- cdb_valid  out  1  registered CDB broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  XLEN  registered broadcast data.
- rf_we  out  1  register-file write enable (RegWrite).
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset (sync, high): busy[0..31]=0, qi[*]=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, rf_we=0, rf_waddr=0, rf_wdata=0. Reset asserted mid-cycle discards any grant that cycle; no write issues the following cycle.
- Arbitration is combinational.
  - req_ready is one-hot or zero.
  - Winner: first asserted req_valid searching from rr_ptr upward, modulo NREQ.
  - On a grant to i, rr_ptr <= (i+1) mod NREQ.
  - With no valid requests, rr_ptr holds.
  - During reset, req_ready=0.
- Handshake: a requester holds valid/tag/rd/data stable until it sees ready. The transfer occurs on the posedge where valid&ready. No combinational dependency of ready on req_data.
- Latency: a granted result appears on cdb_* and rf_* on the next posedge (1 cycle). The register file writes it on the following negedge. cdb_valid and rf_we are single-cycle pulses per grant; back-to-back grants give back-to-back pulses.
- CDB: cdb_valid=1 for every grant, regardless of tag match, so reservation stations always snoop.
- RF write filter, with g = granted request: rf_we=1 only if req_rd[g]!=0 && busy[rd] && qi[rd]==req_tag[g]. On a write, busy[rd] is cleared the same posedge. A stale tag (rd re-renamed) gives rf_we=0 and the table is unchanged.
- Issue: iss_valid && iss_rd!=0 sets busy[iss_rd]=1 and qi[iss_rd]=iss_tag. Issue with iss_rd==0 is ignored.
- Simultaneous issue and matching writeback to the same rd: the RF write still occurs (rf_we=1). The table takes the issue values (busy=1, qi=iss_tag); issue wins.
- Query outputs are combinational reads of the table state (pre-update). Address 0 returns busy=0, tag=0.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins. rr_ptr is not implemented. All other behaviour is identical.

Test Plan:
- Reset, then idle. Expect all outputs 0, req_ready=0, q_busy1=0 for any address.
- Issue rd=5 tag=3. Next cycle, req0 valid rd=5 tag=3 data=0xDEADBEEF. Expect req_ready=001 that cycle. Next cycle: cdb_valid=1, cdb_tag=3, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Then q_busy(5)=0.
- Issue rd=7 tag=1, then rd=7 tag=2. Result tag=1 rd=7 arrives. Expect cdb_valid=1, rf_we=0, q_tag(7)=2, busy held.
- RR_ARB_EN defined; req_valid=111 held for 4 cycles. Expect grants 001, 010, 100, 001. With the macro undefined, expect 001 each cycle.
- Same cycle: issue rd=9 tag=6 and result rd=9 tag=4 (current qi=4). Expect rf_we=1 next cycle with waddr=9. Then busy(9)=1, q_tag(9)=6.
- Result rd=0 tag=2: cdb_valid=1, rf_we=0. Assert reset while req_valid=111: req_ready=000, and the next cycle cdb_valid=0, rf_we=0.
